inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter DEPTH, default 2, output FIFO entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request fields valid.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 in_inst_type  input  INST_TYPE_WIDTH  one of INST_TYPE_IMM, INST_TYPE_INT_IMM, INST_TYPE_INT_REG, INST_TYPE_BRANCH.
REQ-007 in_imm  input  IMM_WIDTH (32)  immediate, byte/sign form as the decoder emits it.
REQ-008 in_rd, in_rs1, in_rs2  input  REG_WIDTH (5) each  register indices.
REQ-009 in_funct  input  FUNCT_WIDTH (4)  bit3 = alternate (SUB/SRA) select, bits[2:0] = funct3.
REQ-010 out_valid  output  1  out_inst holds an encoded word.
REQ-011 out_ready  input  1  consumer takes out_inst this cycle.
REQ-012 out_inst  output  INST_WIDTH (32)  encoded RV32I instruction word.
REQ-013 err  output  1  one-cycle pulse: an accepted request was unencodable.
REQ-014 enc_count  output  16  number of words pushed into the FIFO since reset, wrapping 0xFFFF->0.

Function
REQ-015 A request SHALL be accepted on a cycle where in_valid and in_ready are both 1; a word SHALL be popped on a cycle where out_valid and out_ready are both 1.
REQ-016 Encoding: IMM SHALL produce {imm[31:12], rd, 7'b0110111}; INT_IMM SHALL produce {imm[11:0], rs1, funct[2:0], rd, 7'b0010011}.
REQ-017 INT_REG SHALL produce {funct[3] ? 7'd32 : 7'd0, rs2, rs1, funct[2:0], rd, 7'b0110011}.
REQ-018 BRANCH SHALL produce {imm[12], imm[10:5], rs2, rs1, funct[2:0], imm[4:1], imm[11], 7'b1100011}.
REQ-019 Encodability rules: IMM requires imm[11:0]==0; INT_IMM requires imm[31:11] all equal; BRANCH requires imm[31:12] all equal and imm[0]==0; INT_REG is always encodable; any other inst_type SHALL be unencodable.
REQ-020 An accepted unencodable request SHALL be dropped, with no FIFO push and no enc_count change, and err SHALL be 1 in the following cycle only.
REQ-021 An accepted encodable request SHALL be pushed, and SHALL be visible at the FIFO head no earlier than the next cycle (latency 1 when the FIFO is empty).
REQ-022 in_ready SHALL be 1 exactly when FIFO occupancy < DEPTH, computed from registered occupancy; a same-cycle pop SHALL NOT raise in_ready.
REQ-023 out_valid SHALL be 1 exactly when occupancy > 0; out_inst SHALL be the oldest entry, in FIFO order.
REQ-024 out_inst and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged; the read and write pointers SHALL wrap modulo DEPTH.
REQ-026 out_ready with out_valid=0 SHALL have no effect; in_valid with in_ready=0 SHALL have no effect, and the requester SHALL hold its fields.
REQ-027 enc_count SHALL increment by exactly 1 per push.

Reset
REQ-028 While rst=0: occupancy=0, out_valid=0, in_ready=0, err=0, enc_count=0, out_inst=0.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents and any pending err pulse immediately.
REQ-030 in_ready SHALL rise on the first clk edge after rst deasserts.

Structure
REQ-031 Opcode constants (LUI, OP-IMM, OP, BRANCH), the INST_TYPE_* codes and the widths SHALL live in the shared copperv_h header, alongside those idecoder uses; none SHALL be redefined locally.
REQ-032 Field packing and the encodability check SHALL be combinational; storage SHALL be one sub-module inst_fifo (DEPTH x 32, valid/ready on both sides).

Verification
REQ-033 IMM, imm=0x12345000, rd=5 -> out_inst=0x123452B7 one cycle later; enc_count=1.
REQ-034 INT_IMM, imm=0xFFFFFFFF, rs1=1, funct=0, rd=2 -> 0xFFF08113; then imm=0x00000800 -> err pulse, no output, enc_count unchanged.
REQ-035 INT_REG, funct=4'b1000, rs2=3, rs1=2, rd=1 -> 0x403100B3; round-tripped through idecoder, the bench SHALL check that decoded imm and funct match the request.
REQ-036 BRANCH, imm=0xFFFFFFFC, rs1=1, rs2=2, funct=0 -> 0xFE208EE3; imm=0x00000002 -> 0x00200163; imm=0x1001 -> err.
REQ-037 out_ready=0 with 3 back-to-back requests (DEPTH=2) -> in_ready=0 after 2 accepts; then out_ready=1 -> words emerge in order, and the 3rd is accepted once occupancy < 2.
REQ-038 Assert rst while occupancy=2 -> out_valid=0 immediately, enc_count=0, and no stale word appears after release.

Source files
------------

// File: rtl/copperv_h.sv
// Shared copperv definitions: widths, RV32I opcodes and the inst_type codes
// used by both the decoder and the encoder.
package copperv_h;
  localparam int INST_WIDTH      = 32;
  localparam int IMM_WIDTH       = 32;
  localparam int REG_WIDTH       = 5;
  localparam int FUNCT_WIDTH     = 4;
  localparam int INST_TYPE_WIDTH = 3;
  localparam int OPCODE_WIDTH    = 7;

  typedef logic [OPCODE_WIDTH-1:0]    opcode_t;
  typedef logic [INST_TYPE_WIDTH-1:0] inst_type_t;

  localparam opcode_t OPCODE_LOAD   = 7'b0000011;
  localparam opcode_t OPCODE_OP_IMM = 7'b0010011;
  localparam opcode_t OPCODE_AUIPC  = 7'b0010111;
  localparam opcode_t OPCODE_STORE  = 7'b0100011;
  localparam opcode_t OPCODE_OP     = 7'b0110011;
  localparam opcode_t OPCODE_LUI    = 7'b0110111;
  localparam opcode_t OPCODE_BRANCH = 7'b1100011;
  localparam opcode_t OPCODE_JALR   = 7'b1100111;
  localparam opcode_t OPCODE_JAL    = 7'b1101111;

  // Code 0 and codes above BRANCH are deliberately left undefined.
  localparam inst_type_t INST_TYPE_IMM     = 3'd1;
  localparam inst_type_t INST_TYPE_INT_IMM = 3'd2;
  localparam inst_type_t INST_TYPE_INT_REG = 3'd3;
  localparam inst_type_t INST_TYPE_BRANCH  = 3'd4;

  // True when bits [31:lsb] of v are all 0 or all 1, i.e. v fits a signed
  // field whose sign bit sits at position lsb.
  function automatic logic upper_uniform(input logic [IMM_WIDTH-1:0] v, input int lsb);
    logic [IMM_WIDTH-1:0] m;
    m = '1 << lsb;
    return ((v & m) == m) || ((v & m) == '0);
  endfunction
endpackage

// File: rtl/inst_fifo.sv
// Small valid/ready FIFO holding encoded words. Occupancy, pointers and the
// post-reset enable are all registered, so push_ready never depends on a
// same-cycle pop.
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_d, mem_q;
  logic [PTR_W-1:0]            wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]            cnt_d, cnt_q;
  logic                        live_d, live_q;
  logic                        do_push, do_pop;

  // live_q holds ready low through reset and for the release edge itself.
  assign push_ready = live_q && (cnt_q < CNT_W'(DEPTH));
  assign pop_valid  = (cnt_q != '0);
  assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop_valid & pop_ready;

  // Next-state: write at wr_ptr, advance pointers (wrap is free for 2^n depth).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    live_d   = 1'b1;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      live_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      live_q   <= live_d;
    end
  end
endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoder-style request fields back into an
// instruction word, drops unencodable requests with a one-cycle err pulse,
// and queues good words in inst_fifo.
module inst_encoder
  import copperv_h::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_TYPE_WIDTH-1:0] in_inst_type,
  input  logic [IMM_WIDTH-1:0]       in_imm,
  input  logic [REG_WIDTH-1:0]       in_rd,
  input  logic [REG_WIDTH-1:0]       in_rs1,
  input  logic [REG_WIDTH-1:0]       in_rs2,
  input  logic [FUNCT_WIDTH-1:0]     in_funct,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_WIDTH-1:0]      out_inst,
  output logic                       err,
  output logic [15:0]                enc_count
);
  logic                  accept, push, enc_ok;
  logic [INST_WIDTH-1:0] enc_word;
  logic                  err_d, err_q;
  logic [15:0]           enc_count_d, enc_count_q;

  assign accept = in_valid & in_ready;
  assign push   = accept & enc_ok;

  // Field packing and encodability check, purely combinational.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (in_inst_type)
      INST_TYPE_IMM: begin
        enc_ok   = (in_imm[11:0] == 12'd0);
        enc_word = {in_imm[31:12], in_rd, OPCODE_LUI};
      end
      INST_TYPE_INT_IMM: begin
        enc_ok   = upper_uniform(in_imm, 11);
        enc_word = {in_imm[11:0], in_rs1, in_funct[2:0], in_rd, OPCODE_OP_IMM};
      end
      INST_TYPE_INT_REG: begin
        enc_ok   = 1'b1;
        enc_word = {(in_funct[3] ? 7'd32 : 7'd0), in_rs2, in_rs1, in_funct[2:0],
                    in_rd, OPCODE_OP};
      end
      INST_TYPE_BRANCH: begin
        enc_ok   = upper_uniform(in_imm, 12) && !in_imm[0];
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct[2:0],
                    in_imm[4:1], in_imm[11], OPCODE_BRANCH};
      end
      default: begin
        enc_ok   = 1'b0;
        enc_word = '0;
      end
    endcase
  end

  // err flags a dropped request for the following cycle; counter tracks pushes.
  always_comb begin
    err_d       = accept & ~enc_ok;
    enc_count_d = enc_count_q + 16'(push);
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q       <= 1'b0;
      enc_count_q <= '0;
    end else begin
      err_q       <= err_d;
      enc_count_q <= enc_count_d;
    end
  end

  assign err       = err_q;
  assign enc_count = enc_count_q;

  inst_fifo #(.DEPTH(DEPTH), .WIDTH(INST_WIDTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push),
    .push_ready (in_ready),
    .push_data  (enc_word),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (out_inst)
  );
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with hand-computed instruction words.
module tb_inst_encoder;
  import copperv_h::*;

  localparam int DEPTH = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [INST_TYPE_WIDTH-1:0] in_inst_type = '0;
  logic [IMM_WIDTH-1:0]       in_imm = '0;
  logic [REG_WIDTH-1:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [FUNCT_WIDTH-1:0]     in_funct = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [INST_WIDTH-1:0]      out_inst;
  logic                       err;
  logic [15:0]                enc_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_cnt = '0;

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_type(in_inst_type), .in_imm(in_imm), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct(in_funct),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err(err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] t, input logic [31:0] imm, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [3:0] f);
    in_inst_type = t; in_imm = imm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct = f;
    in_valid = 1'b1;
  endtask

  // Present a request and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [3:0] f);
    drive(t, imm, rd, rs1, rs2, f);
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready=%b after 20 cycles, need 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b need 0", err); end
    vectors++; if (enc_count !== 16'd0) begin miscompares++; $display("FAIL rst_enc_count: got %h need 0", enc_count); end
    vectors++; if (out_inst !== 32'd0) begin miscompares++; $display("FAIL rst_out_inst: got %h need 0", out_inst); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rel_in_ready_early: got %b need 0", in_ready); end
    @(posedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready: got %b need 1", in_ready); end
  endtask

  task automatic test_imm();
    send(INST_TYPE_IMM, 32'h12345000, 5'd5, 5'd0, 5'd0, 4'd0);
    exp_cnt++;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL imm_valid: got %b need 1", out_valid); end
    vectors++; if (out_inst !== 32'h123452B7) begin miscompares++; $display("FAIL imm_word: got %h need 123452b7", out_inst); end
    vectors++; if (enc_count !== exp_cnt) begin miscompares++; $display("FAIL imm_count: got %h need %h", enc_count, exp_cnt); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL imm_err: got %b need 0", err); end
    pop();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL imm_popped: got %b need 0", out_valid); end
    // Popping an empty FIFO must change nothing.
    pop();
    vectors++; if (out_valid !== 1'b0 || enc_count !== exp_cnt) begin miscompares++; $display("FAIL empty_pop: valid %b count %h need 0 %h", out_valid, enc_count, exp_cnt); end
    send(INST_TYPE_IMM, 32'h12345800, 5'd5, 5'd0, 5'd0, 4'd0);
    vectors++; if (err !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL imm_bad: err %b valid %b need 1 0", err, out_valid); end
    @(posedge clk); #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL imm_bad_pulse: err %b need 0", err); end
  endtask

  task automatic test_int_imm();
    send(INST_TYPE_INT_IMM, 32'hFFFFFFFF, 5'd2, 5'd1, 5'd0, 4'd0);
    exp_cnt++;
    vectors++; if (out_inst !== 32'hFFF08113) begin miscompares++; $display("FAIL intimm_neg: got %h need fff08113", out_inst); end
    pop();
    send(INST_TYPE_INT_IMM, 32'h000007FF, 5'd2, 5'd1, 5'd0, 4'd0);
    exp_cnt++;
    vectors++; if (out_inst !== 32'h7FF08113) begin miscompares++; $display("FAIL intimm_max: got %h need 7ff08113", out_inst); end
    pop();
    send(INST_TYPE_INT_IMM, 32'h00000800, 5'd2, 5'd1, 5'd0, 4'd0);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL intimm_err: got %b need 1", err); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL intimm_drop: got %b need 0", out_valid); end
    vectors++; if (enc_count !== exp_cnt) begin miscompares++; $display("FAIL intimm_count: got %h need %h", enc_count, exp_cnt); end
    @(posedge clk); #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL intimm_pulse: got %b need 0", err); end
  endtask

  task automatic test_int_reg();
    logic [3:0]  dec_funct;
    logic [31:0] dec_imm;
    send(INST_TYPE_INT_REG, 32'd0, 5'd1, 5'd2, 5'd3, 4'b1000);
    exp_cnt++;
    vectors++; if (out_inst !== 32'h403100B3) begin miscompares++; $display("FAIL intreg_sub: got %h need 403100b3", out_inst); end
    // Decode back the way the decoder does for an OP word: funct = {b30, funct3}, no immediate.
    dec_funct = {out_inst[30], out_inst[14:12]};
    dec_imm   = 32'd0;
    vectors++; if (dec_funct !== 4'b1000 || out_inst[6:0] !== OPCODE_OP) begin miscompares++; $display("FAIL intreg_rt_funct: got %b op %b need 1000 0110011", dec_funct, out_inst[6:0]); end
    vectors++; if (dec_imm !== 32'd0 || out_inst[11:7] !== 5'd1 || out_inst[19:15] !== 5'd2 || out_inst[24:20] !== 5'd3) begin miscompares++; $display("FAIL intreg_rt_fields: imm %h rd %0d rs1 %0d rs2 %0d need 0 1 2 3", dec_imm, out_inst[11:7], out_inst[19:15], out_inst[24:20]); end
    pop();
    send(INST_TYPE_INT_REG, 32'd0, 5'd5, 5'd6, 5'd7, 4'b0101);
    exp_cnt++;
    vectors++; if (out_inst !== 32'h007352B3) begin miscompares++; $display("FAIL intreg_srl: got %h need 007352b3", out_inst); end
    pop();
  endtask

  task automatic test_branch();
    send(INST_TYPE_BRANCH, 32'hFFFFFFFC, 5'd0, 5'd1, 5'd2, 4'd0);
    exp_cnt++;
    vectors++; if (out_inst !== 32'hFE208EE3) begin miscompares++; $display("FAIL br_neg: got %h need fe208ee3", out_inst); end
    pop();
    send(INST_TYPE_BRANCH, 32'h00000002, 5'd0, 5'd0, 5'd2, 4'd0);
    exp_cnt++;
    vectors++; if (out_inst !== 32'h00200163) begin miscompares++; $display("FAIL br_pos: got %h need 00200163", out_inst); end
    pop();
    send(INST_TYPE_BRANCH, 32'h00001001, 5'd0, 5'd1, 5'd2, 4'd0);
    vectors++; if (err !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL br_odd: err %b valid %b need 1 0", err, out_valid); end
    send(INST_TYPE_BRANCH, 32'h00001000, 5'd0, 5'd1, 5'd2, 4'd0);
    vectors++; if (err !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL br_range: err %b valid %b need 1 0", err, out_valid); end
    vectors++; if (enc_count !== exp_cnt) begin miscompares++; $display("FAIL br_count: got %h need %h", enc_count, exp_cnt); end
  endtask

  task automatic test_bad_type();
    send(3'd0, 32'd0, 5'd1, 5'd1, 5'd1, 4'd0);
    vectors++; if (err !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL type0: err %b valid %b need 1 0", err, out_valid); end
    send(3'd7, 32'd0, 5'd1, 5'd1, 5'd1, 4'd0);
    vectors++; if (err !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL type7: err %b valid %b need 1 0", err, out_valid); end
    @(posedge clk); #1;
    vectors++; if (err !== 1'b0 || enc_count !== exp_cnt) begin miscompares++; $display("FAIL type_after: err %b count %h need 0 %h", err, enc_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(INST_TYPE_IMM, 32'h00001000, 5'd1, 5'd0, 5'd0, 4'd0);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_rdy0: got %b need 1", in_ready); end
    @(posedge clk); #1;
    drive(INST_TYPE_IMM, 32'h00002000, 5'd2, 5'd0, 5'd0, 4'd0);
    vectors++; if (in_ready !== 1'b1 || out_inst !== 32'h000010B7) begin miscompares++; $display("FAIL b2b_a: rdy %b word %h need 1 000010b7", in_ready, out_inst); end
    @(posedge clk); #1;
    drive(INST_TYPE_IMM, 32'h00003000, 5'd3, 5'd0, 5'd0, 4'd0);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full: rdy %b need 0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h000010B7 || enc_count !== exp_cnt + 16'd2) begin miscompares++; $display("FAIL b2b_hold: rdy %b valid %b word %h count %h need 0 1 000010b7 %h", in_ready, out_valid, out_inst, enc_count, exp_cnt + 16'd2); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_inst !== 32'h00002137 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_b: word %h rdy %b need 00002137 1", out_inst, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_inst !== 32'h000031B7 || enc_count !== exp_cnt + 16'd3) begin miscompares++; $display("FAIL b2b_c: valid %b word %h count %h need 1 000031b7 %h", out_valid, out_inst, enc_count, exp_cnt + 16'd3); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd3;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: valid %b need 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    send(INST_TYPE_IMM, 32'h00001000, 5'd1, 5'd0, 5'd0, 4'd0);
    send(INST_TYPE_IMM, 32'h00002000, 5'd2, 5'd0, 5'd0, 4'd0);
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_full: rdy %b valid %b need 0 1", in_ready, out_valid); end
    #2 rst = 1'b0;
    #1;
    exp_cnt = '0;
    vectors++; if (out_valid !== 1'b0 || out_inst !== 32'd0) begin miscompares++; $display("FAIL mid_flush: valid %b word %h need 0 0", out_valid, out_inst); end
    vectors++; if (enc_count !== 16'd0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_count: count %h rdy %b need 0 0", enc_count, in_ready); end
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0 || out_inst !== 32'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release: valid %b word %h rdy %b need 0 0 1", out_valid, out_inst, in_ready); end
    // A pending err pulse must vanish the moment reset asserts.
    send(INST_TYPE_IMM, 32'h00000001, 5'd1, 5'd0, 5'd0, 4'd0);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL mid_err_set: err %b need 1", err); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL mid_err_clear: err %b need 0", err); end
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    send(INST_TYPE_IMM, 32'h12345000, 5'd5, 5'd0, 5'd0, 4'd0);
    exp_cnt++;
    vectors++; if (out_inst !== 32'h123452B7 || enc_count !== exp_cnt) begin miscompares++; $display("FAIL mid_restart: word %h count %h need 123452b7 %h", out_inst, enc_count, exp_cnt); end
    pop();
  endtask

  initial begin
    test_reset();
    test_imm();
    test_int_imm();
    test_int_reg();
    test_branch();
    test_bad_type();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
